// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: execute->memory and memory->writeback bus layouts
// and the memory-stage state encoding.
package pipe_pkg;

  localparam int unsigned EXE_MEM_W = 78;
  localparam int unsigned MEM_WB_W  = 71;

  // execute -> memory field offsets (LSB positions)
  localparam int unsigned IN_EXC      = 0;
  localparam int unsigned IN_REQ      = 1;
  localparam int unsigned IN_LDW      = 2;
  localparam int unsigned IN_LDHU     = 3;
  localparam int unsigned IN_LDH      = 4;
  localparam int unsigned IN_LDBU     = 5;
  localparam int unsigned IN_LDB      = 6;
  localparam int unsigned IN_PC_LSB   = 7;
  localparam int unsigned IN_RES_LSB  = 39;
  localparam int unsigned IN_DEST_LSB = 71;
  localparam int unsigned IN_GRWE     = 76;
  localparam int unsigned IN_RFM      = 77;

  // memory -> writeback field offsets
  localparam int unsigned OUT_EXC       = 0;
  localparam int unsigned OUT_PC_LSB    = 1;
  localparam int unsigned OUT_WDATA_LSB = 33;
  localparam int unsigned OUT_DEST_LSB  = 65;
  localparam int unsigned OUT_GRWE      = 70;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

endpackage

// File: rtl/mem_stage_if.sv
// Handshake, bus, SRAM-response and hazard signals of the memory stage.
interface mem_stage_if
  import pipe_pkg::*;
#(
  parameter int unsigned IN_W  = EXE_MEM_W,
  parameter int unsigned OUT_W = MEM_WB_W
);
  logic             exe_to_mem_valid;
  logic [IN_W-1:0]  exe_to_mem_bus;
  logic             mem_allow;
  logic             wb_allow;
  logic             mem_to_wb_valid;
  logic [OUT_W-1:0] mem_to_wb_bus;
  logic             data_sram_data_ok;
  logic [31:0]      data_sram_rdata;
  logic             wb_exception;
  logic             mem_exception;
  logic [4:0]       mem_dest;
  logic [31:0]      mem_value;
  logic             mem_load_stall;

  modport master (
    output exe_to_mem_valid, exe_to_mem_bus, wb_allow,
           data_sram_data_ok, data_sram_rdata, wb_exception,
    input  mem_allow, mem_to_wb_valid, mem_to_wb_bus,
           mem_exception, mem_dest, mem_value, mem_load_stall
  );

  modport slave (
    input  exe_to_mem_valid, exe_to_mem_bus, wb_allow,
           data_sram_data_ok, data_sram_rdata, wb_exception,
    output mem_allow, mem_to_wb_valid, mem_to_wb_bus,
           mem_exception, mem_dest, mem_value, mem_load_stall
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load-data extraction: selects byte/half by address offset and
// sign- or zero-extends it to 32 bits.
module load_align (
  input  logic [1:0]  off_i,
  input  logic        ld_b_i,
  input  logic        ld_bu_i,
  input  logic        ld_h_i,
  input  logic        ld_hu_i,
  input  logic        ld_w_i,
  input  logic [31:0] raw_i,
  output logic [31:0] value_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = '0;
    case (off_i)
      2'd0:    byte_v = raw_i[7:0];
      2'd1:    byte_v = raw_i[15:8];
      2'd2:    byte_v = raw_i[23:16];
      default: byte_v = raw_i[31:24];
    endcase
    half_v = off_i[1] ? raw_i[31:16] : raw_i[15:0];
  end

  always_comb begin
    value_o = '0;
    if (ld_b_i)       value_o = {{24{byte_v[7]}}, byte_v};
    else if (ld_bu_i) value_o = {24'h0, byte_v};
    else if (ld_h_i)  value_o = {{16{half_v[15]}}, half_v};
    else if (ld_hu_i) value_o = {16'h0, half_v};
    else if (ld_w_i)  value_o = raw_i;
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for in-order data-SRAM responses, aligns
// load data, discards responses orphaned by flushes, and publishes hazard info.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int unsigned IN_W   = EXE_MEM_W,
  parameter int unsigned OUT_W  = MEM_WB_W,
  parameter int unsigned DROP_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  io
);
  logic              valid_q, valid_d;
  logic [IN_W-1:0]   bus_q, bus_d;
  logic [1:0]        state_q, state_d;
  logic [31:0]       rdata_buf_q, rdata_buf_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic        rfm, gr_we, req_sent, exc;
  logic [4:0]  dest;
  logic [31:0] result, pc, ld_val, raw, wdata;
  logic        live_ok, data_have, mem_go, mem_allow, load, in_req;
  logic        drop_inc, drop_dec;
  logic [OUT_W-1:0] out_bus;

  assign rfm      = bus_q[IN_RFM];
  assign gr_we    = bus_q[IN_GRWE];
  assign dest     = bus_q[IN_DEST_LSB +: 5];
  assign result   = bus_q[IN_RES_LSB +: 32];
  assign pc       = bus_q[IN_PC_LSB +: 32];
  assign req_sent = bus_q[IN_REQ];
  assign exc      = bus_q[IN_EXC];

  assign live_ok   = io.data_sram_data_ok & (drop_cnt_q == '0);
  assign data_have = (state_q == S_HOLD) | ((state_q == S_WAIT) & live_ok);
  assign mem_go    = ~req_sent | data_have;
  assign mem_allow = ~valid_q | (mem_go & io.wb_allow);
  assign load      = mem_allow & io.exe_to_mem_valid & ~io.wb_exception;
  assign in_req    = io.exe_to_mem_bus[IN_REQ] & ~io.exe_to_mem_bus[IN_EXC];

  // A flush while still waiting orphans one response; a strobe seen while
  // orphans are pending retires one. Both together leave the count unchanged.
  assign drop_inc = io.wb_exception & (state_q == S_WAIT) & ~live_ok;
  assign drop_dec = io.data_sram_data_ok & (drop_cnt_q != '0);

  always_comb begin
    valid_d     = valid_q;
    bus_d       = bus_q;
    state_d     = state_q;
    rdata_buf_d = rdata_buf_q;
    drop_cnt_d  = drop_cnt_q;

    if (io.wb_exception) begin
      valid_d = 1'b0;
      state_d = S_IDLE;
    end else if (load) begin
      valid_d = 1'b1;
      bus_d   = io.exe_to_mem_bus;
      state_d = in_req ? S_WAIT : S_IDLE;
    end else if (mem_allow) begin
      valid_d = 1'b0;
      state_d = S_IDLE;
    end else if ((state_q == S_WAIT) & live_ok) begin
      rdata_buf_d = io.data_sram_rdata;
      state_d     = S_HOLD;
    end

    if (drop_inc & ~drop_dec)      drop_cnt_d = drop_cnt_q + 1'b1;
    else if (drop_dec & ~drop_inc) drop_cnt_d = drop_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q     <= 1'b0;
      bus_q       <= '0;
      state_q     <= S_IDLE;
      rdata_buf_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      bus_q       <= bus_d;
      state_q     <= state_d;
      rdata_buf_q <= rdata_buf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  a_drop_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(drop_inc && !drop_dec && (drop_cnt_q == '1)));

  assign raw = (state_q == S_HOLD) ? rdata_buf_q : io.data_sram_rdata;

  load_align u_load_align (
    .off_i   (result[1:0]),
    .ld_b_i  (bus_q[IN_LDB]),
    .ld_bu_i (bus_q[IN_LDBU]),
    .ld_h_i  (bus_q[IN_LDH]),
    .ld_hu_i (bus_q[IN_LDHU]),
    .ld_w_i  (bus_q[IN_LDW]),
    .raw_i   (raw),
    .value_o (ld_val)
  );

  assign wdata   = rfm ? ld_val : result;
  assign out_bus = {gr_we, dest, wdata, pc, exc};

  assign io.mem_allow       = mem_allow;
  assign io.mem_to_wb_valid = valid_q & mem_go;
  assign io.mem_to_wb_bus   = out_bus;
  assign io.mem_exception   = valid_q & exc;
  assign io.mem_dest        = (valid_q & gr_we) ? dest : 5'd0;
  assign io.mem_value       = wdata;
  assign io.mem_load_stall  = valid_q & rfm & ~data_have;
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  localparam logic [4:0] LD_B  = 5'b10000;
  localparam logic [4:0] LD_BU = 5'b01000;
  localparam logic [4:0] LD_H  = 5'b00100;
  localparam logic [4:0] LD_HU = 5'b00010;
  localparam logic [4:0] LD_W  = 5'b00001;

  mem_stage_if #(.IN_W(78), .OUT_W(71)) bus_if ();

  mem_stage #(.IN_W(78), .OUT_W(71), .DROP_W(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (bus_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [77:0] mk(input logic rfm, input logic gr_we,
                                     input logic [4:0] dest, input logic [31:0] res,
                                     input logic [31:0] pc, input logic [4:0] ld,
                                     input logic req, input logic exc);
    return {rfm, gr_we, dest, res, pc, ld, req, exc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.exe_to_mem_valid  = 1'b0;
    bus_if.exe_to_mem_bus    = '0;
    bus_if.wb_allow          = 1'b1;
    bus_if.data_sram_data_ok = 1'b0;
    bus_if.data_sram_rdata   = '0;
    bus_if.wb_exception      = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    tick();
    tick();
    @(negedge clk);
    n_checks++; if (bus_if.mem_allow !== 1'b1) begin n_fail++; $display("FAIL reset_allow: got %b want 1", bus_if.mem_allow); end
    n_checks++; if (bus_if.mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus_if.mem_to_wb_valid); end
    n_checks++; if (bus_if.mem_to_wb_bus !== 71'h0) begin n_fail++; $display("FAIL reset_bus: got %h want 0", bus_if.mem_to_wb_bus); end
    n_checks++; if ({bus_if.mem_dest, bus_if.mem_value, bus_if.mem_load_stall, bus_if.mem_exception} !== 39'h0) begin
      n_fail++; $display("FAIL reset_hazard: dest=%h value=%h stall=%b exc=%b want all 0",
                         bus_if.mem_dest, bus_if.mem_value, bus_if.mem_load_stall, bus_if.mem_exception); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_ld_b();
    bus_if.exe_to_mem_bus   = mk(1'b1, 1'b1, 5'd3, 32'h1003, 32'h100, LD_B, 1'b1, 1'b0);
    bus_if.exe_to_mem_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (bus_if.mem_allow !== 1'b1) begin n_fail++; $display("FAIL ldb_accept: got %b want 1", bus_if.mem_allow); end
    tick();
    bus_if.exe_to_mem_valid  = 1'b0;
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = 32'h80112233;
    @(negedge clk);
    n_checks++; if (bus_if.mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL ldb_valid: got %b want 1", bus_if.mem_to_wb_valid); end
    n_checks++; if (bus_if.mem_to_wb_bus[64:33] !== 32'hFFFFFF80) begin n_fail++; $display("FAIL ldb_wdata: got %h want ffffff80", bus_if.mem_to_wb_bus[64:33]); end
    n_checks++; if (bus_if.mem_load_stall !== 1'b0) begin n_fail++; $display("FAIL ldb_stall: got %b want 0", bus_if.mem_load_stall); end
    n_checks++; if (bus_if.mem_to_wb_bus[70:65] !== 6'b100011 || bus_if.mem_to_wb_bus[32:1] !== 32'h100) begin
      n_fail++; $display("FAIL ldb_fields: we/dest=%b pc=%h want 100011 / 00000100", bus_if.mem_to_wb_bus[70:65], bus_if.mem_to_wb_bus[32:1]); end
    tick();
    bus_if.data_sram_data_ok = 1'b0;
    @(negedge clk);
    n_checks++; if (bus_if.mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL ldb_pulse: got %b want 0", bus_if.mem_to_wb_valid); end
    tick();
  endtask

  task automatic test_hold();
    bus_if.exe_to_mem_bus   = mk(1'b1, 1'b1, 5'd7, 32'h2002, 32'h200, LD_HU, 1'b1, 1'b0);
    bus_if.exe_to_mem_valid = 1'b1;
    tick();
    bus_if.exe_to_mem_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus_if.mem_load_stall !== 1'b1 || bus_if.mem_allow !== 1'b0 || bus_if.mem_to_wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_wait: stall=%b allow=%b valid=%b want 1 0 0", bus_if.mem_load_stall, bus_if.mem_allow, bus_if.mem_to_wb_valid); end
    tick();
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = 32'hBEEF1234;
    bus_if.wb_allow          = 1'b0;
    @(negedge clk);
    n_checks++; if (bus_if.mem_to_wb_valid !== 1'b1 || bus_if.mem_allow !== 1'b0) begin
      n_fail++; $display("FAIL hold_dataok: valid=%b allow=%b want 1 0", bus_if.mem_to_wb_valid, bus_if.mem_allow); end
    tick();
    bus_if.data_sram_data_ok = 1'b0;
    bus_if.data_sram_rdata   = 32'h5555AAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (dut.state_q !== 2'd2) begin n_fail++; $display("FAIL hold_state[%0d]: got %0d want 2", i, dut.state_q); end
      n_checks++; if (bus_if.mem_allow !== 1'b0 || bus_if.mem_to_wb_valid !== 1'b1 || bus_if.mem_to_wb_bus[64:33] !== 32'h0000BEEF) begin
        n_fail++; $display("FAIL hold_stable[%0d]: allow=%b valid=%b wdata=%h want 0 1 0000beef",
                           i, bus_if.mem_allow, bus_if.mem_to_wb_valid, bus_if.mem_to_wb_bus[64:33]); end
      tick();
    end
    bus_if.wb_allow = 1'b1;
    @(negedge clk);
    n_checks++; if (bus_if.mem_to_wb_bus[64:33] !== 32'h0000BEEF || bus_if.mem_allow !== 1'b1) begin
      n_fail++; $display("FAIL hold_release: wdata=%h allow=%b want 0000beef 1", bus_if.mem_to_wb_bus[64:33], bus_if.mem_allow); end
    tick();
    @(negedge clk);
    n_checks++; if (dut.state_q !== 2'd0 || bus_if.mem_to_wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_idle: state=%0d valid=%b want 0 0", dut.state_q, bus_if.mem_to_wb_valid); end
    tick();
  endtask

  task automatic test_forward();
    bus_if.exe_to_mem_bus   = mk(1'b0, 1'b1, 5'd5, 32'h12345678, 32'h300, 5'b0, 1'b0, 1'b0);
    bus_if.exe_to_mem_valid = 1'b1;
    tick();
    bus_if.exe_to_mem_valid = 1'b0;
    bus_if.wb_allow         = 1'b0;
    @(negedge clk);
    n_checks++; if (bus_if.mem_dest !== 5'd5 || bus_if.mem_value !== 32'h12345678 || bus_if.mem_load_stall !== 1'b0) begin
      n_fail++; $display("FAIL fwd: dest=%0d value=%h stall=%b want 5 12345678 0", bus_if.mem_dest, bus_if.mem_value, bus_if.mem_load_stall); end
    n_checks++; if (bus_if.mem_to_wb_valid !== 1'b1 || bus_if.mem_allow !== 1'b0) begin
      n_fail++; $display("FAIL fwd_hs: valid=%b allow=%b want 1 0", bus_if.mem_to_wb_valid, bus_if.mem_allow); end
    bus_if.wb_allow = 1'b1;
    tick();
    @(negedge clk);
    n_checks++; if (bus_if.mem_dest !== 5'd0) begin n_fail++; $display("FAIL fwd_clear: dest=%0d want 0", bus_if.mem_dest); end
    // excepting non-memory instruction raises mem_exception while valid
    bus_if.exe_to_mem_bus   = mk(1'b0, 1'b0, 5'd2, 32'h0, 32'h304, 5'b0, 1'b0, 1'b1);
    bus_if.exe_to_mem_valid = 1'b1;
    tick();
    bus_if.exe_to_mem_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus_if.mem_exception !== 1'b1 || bus_if.mem_to_wb_bus[0] !== 1'b1 || bus_if.mem_dest !== 5'd0) begin
      n_fail++; $display("FAIL exc_flag: exc=%b busexc=%b dest=%0d want 1 1 0", bus_if.mem_exception, bus_if.mem_to_wb_bus[0], bus_if.mem_dest); end
    tick();
  endtask

  task automatic test_flush_drop();
    bus_if.exe_to_mem_bus   = mk(1'b1, 1'b1, 5'd8, 32'h3000, 32'h400, LD_W, 1'b1, 1'b0);
    bus_if.exe_to_mem_valid = 1'b1;
    tick();
    bus_if.exe_to_mem_valid = 1'b0;
    bus_if.wb_exception     = 1'b1;
    tick();
    bus_if.wb_exception = 1'b0;
    @(negedge clk);
    n_checks++; if (dut.drop_cnt_q !== 2'd1 || bus_if.mem_to_wb_valid !== 1'b0 || bus_if.mem_allow !== 1'b1) begin
      n_fail++; $display("FAIL flush_inc: drop=%0d valid=%b allow=%b want 1 0 1", dut.drop_cnt_q, bus_if.mem_to_wb_valid, bus_if.mem_allow); end
    bus_if.exe_to_mem_bus   = mk(1'b1, 1'b1, 5'd9, 32'h4000, 32'h500, LD_W, 1'b1, 1'b0);
    bus_if.exe_to_mem_valid = 1'b1;
    tick();
    bus_if.exe_to_mem_valid  = 1'b0;
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = 32'hDEAD0000;
    @(negedge clk);
    n_checks++; if (bus_if.mem_to_wb_valid !== 1'b0 || bus_if.mem_load_stall !== 1'b1) begin
      n_fail++; $display("FAIL drop_stale: valid=%b stall=%b want 0 1", bus_if.mem_to_wb_valid, bus_if.mem_load_stall); end
    tick();
    bus_if.data_sram_rdata = 32'h00C0FFEE;
    @(negedge clk);
    n_checks++; if (dut.drop_cnt_q !== 2'd0) begin n_fail++; $display("FAIL drop_dec: drop=%0d want 0", dut.drop_cnt_q); end
    n_checks++; if (bus_if.mem_to_wb_valid !== 1'b1 || bus_if.mem_to_wb_bus[64:33] !== 32'h00C0FFEE) begin
      n_fail++; $display("FAIL drop_live: valid=%b wdata=%h want 1 00c0ffee", bus_if.mem_to_wb_valid, bus_if.mem_to_wb_bus[64:33]); end
    tick();
    bus_if.data_sram_data_ok = 1'b0;
    tick();
  endtask

  task automatic test_flush_live();
    bus_if.exe_to_mem_bus   = mk(1'b1, 1'b1, 5'd10, 32'h6000, 32'h600, LD_W, 1'b1, 1'b0);
    bus_if.exe_to_mem_valid = 1'b1;
    tick();
    bus_if.exe_to_mem_valid  = 1'b0;
    bus_if.wb_exception      = 1'b1;
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = 32'h11111111;
    tick();
    bus_if.wb_exception      = 1'b0;
    bus_if.data_sram_data_ok = 1'b0;
    @(negedge clk);
    n_checks++; if (dut.drop_cnt_q !== 2'd0 || dut.state_q !== 2'd0) begin
      n_fail++; $display("FAIL flushlive_cnt: drop=%0d state=%0d want 0 0", dut.drop_cnt_q, dut.state_q); end
    n_checks++; if (bus_if.mem_to_wb_valid !== 1'b0 || dut.valid_q !== 1'b0) begin
      n_fail++; $display("FAIL flushlive_valid: out=%b valid=%b want 0 0", bus_if.mem_to_wb_valid, dut.valid_q); end
    tick();
  endtask

  localparam logic [4:0]  T_LD  [8] = '{LD_BU, LD_H, LD_H, LD_B, LD_BU, LD_W, LD_B, LD_HU};
  localparam logic [1:0]  T_OFF [8] = '{2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
  localparam logic [31:0] T_RAW [8] = '{32'h80112233, 32'h80017FFF, 32'h80017FFF, 32'h000000FF,
                                        32'h0000AB00, 32'hA5A55A5A, 32'h00007F00, 32'h1234F00D};
  localparam logic [31:0] T_EXP [8] = '{32'h00000080, 32'hFFFF8001, 32'h00007FFF, 32'hFFFFFFFF,
                                        32'h000000AB, 32'hA5A55A5A, 32'h0000007F, 32'h0000F00D};

  task automatic test_back_to_back();
    for (int i = 0; i <= 8; i++) begin
      bus_if.exe_to_mem_valid = (i < 8);
      if (i < 8)
        bus_if.exe_to_mem_bus = mk(1'b1, 1'b1, 5'(i + 1), 32'h5000 | {30'h0, T_OFF[i]}, 32'h700, T_LD[i], 1'b1, 1'b0);
      bus_if.data_sram_data_ok = (i > 0);
      bus_if.data_sram_rdata   = (i > 0) ? T_RAW[i-1] : 32'h0;
      @(negedge clk);
      if (i > 0) begin
        n_checks++; if (bus_if.mem_to_wb_valid !== 1'b1 || bus_if.mem_to_wb_bus[64:33] !== T_EXP[i-1] || bus_if.mem_allow !== 1'b1) begin
          n_fail++; $display("FAIL b2b[%0d]: valid=%b wdata=%h allow=%b want 1 %h 1",
                             i - 1, bus_if.mem_to_wb_valid, bus_if.mem_to_wb_bus[64:33], bus_if.mem_allow, T_EXP[i-1]); end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    bus_if.exe_to_mem_bus   = mk(1'b1, 1'b1, 5'd11, 32'h7000, 32'h800, LD_W, 1'b1, 1'b0);
    bus_if.exe_to_mem_valid = 1'b1;
    tick();
    bus_if.exe_to_mem_valid = 1'b0;
    bus_if.wb_exception     = 1'b1;
    tick();
    bus_if.wb_exception     = 1'b0;
    bus_if.exe_to_mem_bus   = mk(1'b1, 1'b1, 5'd12, 32'h7004, 32'h804, LD_W, 1'b1, 1'b0);
    bus_if.exe_to_mem_valid = 1'b1;
    tick();
    bus_if.exe_to_mem_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (dut.drop_cnt_q !== 2'd1 || dut.state_q !== 2'd1) begin
      n_fail++; $display("FAIL rstwait_setup: drop=%0d state=%0d want 1 1", dut.drop_cnt_q, dut.state_q); end
    resetn = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if (dut.valid_q !== 1'b0 || dut.state_q !== 2'd0 || dut.drop_cnt_q !== 2'd0 || dut.bus_q !== 78'h0 || dut.rdata_buf_q !== 32'h0) begin
      n_fail++; $display("FAIL rstwait_regs: valid=%b state=%0d drop=%0d bus=%h buf=%h want all 0",
                         dut.valid_q, dut.state_q, dut.drop_cnt_q, dut.bus_q, dut.rdata_buf_q); end
    n_checks++; if (bus_if.mem_allow !== 1'b1 || bus_if.mem_to_wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_out: allow=%b valid=%b want 1 0", bus_if.mem_allow, bus_if.mem_to_wb_valid); end
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_ld_b();
    test_hold();
    test_forward();
    test_flush_drop();
    test_flush_live();
    test_back_to_back();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Sits directly downstream of the execute stage and upstream of writeback.
- Accepts the execute-to-memory bundle and waits for the data-SRAM response to any request issued in execute.
- Extracts and sign/zero-extends load data, then hands a writeback bundle onward.
- Tracks responses still outstanding across pipeline flushes, publishes forwarding/hazard info to decode, and raises its exception flag to block further data requests.

Parameters:
- IN_W, 78, width of the execute-to-memory bus (layout in pipe_pkg).
- OUT_W, 71, width of the memory-to-writeback bus (layout in pipe_pkg).
- DROP_W, 2, width of the dropped-response counter (max 3 outstanding discards).

Ports:
- clk  in  1  clock; one clock; reset is synchronous and active-low.
- resetn  in  1  synchronous active-low reset.
- exe_to_mem_valid  in  1  upstream bundle valid.
- exe_to_mem_bus  in  IN_W  {res_from_mem, gr_we, dest[4:0], result[31:0], pc[31:0], ld_b, ld_bu, ld_h, ld_hu, ld_w, req_sent, exc}, MSB first.
- mem_allow  out  1  stage can accept this cycle.
- wb_allow  in  1  downstream can accept.
- mem_to_wb_valid  out  1  downstream bundle valid.
- mem_to_wb_bus  out  OUT_W  {gr_we, dest[4:0], wdata[31:0], pc[31:0], exc}.
- data_sram_data_ok  in  1  read/write response strobe; responses return in order.
- data_sram_rdata  in  32  response data.
- wb_exception  in  1  flush from writeback.
- mem_exception  out  1  valid & exc.
- mem_dest  out  5  valid & gr_we ? dest : 0.
- mem_value  out  32  final wdata.
- mem_load_stall  out  1  valid & res_from_mem & ~data_have.

Behaviour:
- Registers: valid, bus_r, state {IDLE, WAIT, HOLD}, rdata_buf[31:0], drop_cnt[DROP_W-1:0].
- Reset (resetn=0 at clk edge): all registers 0, state IDLE. All outputs 0: mem_allow=1, mem_to_wb_valid=0.
- live_ok = data_sram_data_ok & (drop_cnt==0).
- data_have = (state==HOLD) | (state==WAIT & live_ok).
- mem_go = ~req_sent | data_have.
- mem_allow = ~valid | (mem_go & wb_allow).
- mem_to_wb_valid = valid & mem_go.
- Load: on mem_allow & exe_to_mem_valid, latch bus_r and set valid. Next state is WAIT if req_sent & ~exc, else IDLE.
- Plain flow: mem_allow=1 and no incoming valid clears valid.
- WAIT, live_ok:
  - wb_allow=1: data passes combinationally; state becomes IDLE, or WAIT if a new requesting instruction loads the same cycle.
  - wb_allow=0: capture data_sram_rdata into rdata_buf and go to HOLD.
- HOLD: rdata_buf is used as the load data. Leave HOLD when the instruction is accepted downstream.
- Dropped responses:
  - data_sram_data_ok with drop_cnt>0 decrements drop_cnt and is never used as data.
  - Stale responses drain before the current one because responses are in order.
- Flush (wb_exception=1):
  - valid cleared and state set to IDLE next cycle; no load accepted that cycle.
  - If state==WAIT and live_ok=0, drop_cnt increments.
  - If the flush coincides with live_ok, the response is consumed and no increment occurs.
  - If the flush coincides with a dropped-response strobe, drop_cnt is unchanged (+1 and -1 cancel).
  - drop_cnt saturating at 2^DROP_W-1 is a protocol error: assertion only.
- Load extract: off = result[1:0].
  - byte = rdata>>(8*off); half = off[1] ? rdata[31:16] : rdata[15:0].
  - ld_b sign-extends byte, ld_bu zero-extends byte, ld_h sign-extends half, ld_hu zero-extends half, ld_w passes the full word.
- wdata = res_from_mem ? extracted value : result. Stores never write a register.
- Forwarding outputs are combinational from current state. mem_value is valid only when mem_load_stall=0.
- Reset mid-WAIT: drop_cnt cleared. The memory side is reset together with this stage, so no stale responses are expected after reset.

Decomposition:
- pipe_pkg holds:
  - IN_W/OUT_W field offsets and widths.
  - state encoding localparams (IDLE=0, WAIT=1, HOLD=2).
- One sub-module: load_align (combinational; inputs off, 5 load flags, 32-bit raw word; output 32-bit extended value). Shared later by the cache refill path.

Test Plan:
- ld.b, result=0x1003, rdata=0x80112233 one cycle after load, wb_allow=1 → mem_to_wb_valid pulses, wdata=0xFFFFFF80, mem_load_stall=0 in that cycle.
- ld.hu, result=0x2002, rdata=0xBEEF1234, wb_allow=0 for 3 cycles after data_ok → state HOLD, mem_allow=0, bus stable. wb_allow=1 → wdata=0x0000BEEF, state IDLE.
- Non-memory instruction (req_sent=0), result=0x12345678, gr_we=1, dest=5 → forwarded same cycle: mem_dest=5, mem_value=0x12345678, mem_load_stall=0.
- ld.w in WAIT, wb_exception asserted, then a new ld.w enters. First data_ok (0xDEAD0000) dropped with drop_cnt 1→0; second data_ok (0x00C0FFEE) yields wdata=0x00C0FFEE.
- wb_exception coincident with live data_ok → drop_cnt stays 0, valid=0 next cycle, nothing emitted downstream.
- resetn=0 during WAIT with drop_cnt=1 → next cycle all registers 0, mem_allow=1, mem_to_wb_valid=0.
